// File: rtl/memory.sv
// Register-file memory: WIDTH entries of DEPTH bits, one synchronous write port,
// one combinational read port with write-first bypass and asynchronous clear.
module memory #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(WIDTH)-1:0] waddr,
    input  logic [$clog2(WIDTH)-1:0] raddr,
    input  logic                     w_en,
    input  logic [DEPTH-1:0]         data_in,
    output logic [DEPTH-1:0]         data_out
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [AW:0] ENTRIES = (AW + 1)'(WIDTH);

    logic [DEPTH-1:0] mem_r [WIDTH];
    logic             waddr_ok_s;
    logic             raddr_ok_s;
    logic             bypass_s;

    // Addresses past the last entry only exist when WIDTH is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < ENTRIES);
    endfunction

    assign waddr_ok_s = in_range(waddr);
    assign raddr_ok_s = in_range(raddr);
    assign bypass_s   = w_en && (waddr == raddr) && raddr_ok_s;

    // Storage: asynchronous clear, otherwise a single-entry write per edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (w_en && waddr_ok_s) begin
            mem_r[waddr] <= data_in;
        end
    end

    // Read path: reset forces zero, bypass returns in-flight write data.
    always_comb begin
        data_out = '0;
        if (reset) begin
            data_out = '0;
        end else if (bypass_s) begin
            data_out = data_in;
        end else if (raddr_ok_s) begin
            data_out = mem_r[raddr];
        end else begin
            data_out = '0;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus queues expected read data, a monitor
// process pops and compares against data_out on every sample request.
module tb_memory;

    logic       clock;
    logic       reset;
    logic [3:0] waddr;
    logic [3:0] raddr;
    logic       w_en;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q  [$];
    string      name_q [$];
    event       sample_ev;

    memory #(.WIDTH(16), .DEPTH(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .waddr   (waddr),
        .raddr   (raddr),
        .w_en    (w_en),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: compare every queued expectation against the live read data.
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                logic [7:0] e;
                string      n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                total++;
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL %s: data_out=%h expected=%h at %0t", n, data_out, e, $time);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string name, input logic [7:0] e);
        exp_q.push_back(e);
        name_q.push_back(name);
        -> sample_ev;
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        w_en    = 1'b1;
        waddr   = a;
        data_in = d;
        @(posedge clock);
        #1;
        w_en = 1'b0;
    endtask

    task automatic read_at(input string name, input logic [3:0] a, input logic [7:0] e);
        @(negedge clock);
        w_en  = 1'b0;
        raddr = a;
        #1;
        expect_out(name, e);
    endtask

    initial begin
        reset   = 1'b1;
        w_en    = 1'b0;
        waddr   = 4'd0;
        raddr   = 4'd0;
        data_in = 8'h00;
        #1;
        expect_out("reset_state", 8'h00);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        expect_out("after_reset_read", 8'h00);

        // Write then read at address 0
        @(negedge clock);
        waddr = 4'd0; raddr = 4'd0; data_in = 8'h05; w_en = 1'b1;
        #1;
        expect_out("wr0_bypass", 8'h05);
        @(posedge clock);
        #1;
        w_en = 1'b0; data_in = 8'h00;
        #1;
        expect_out("wr0_stored", 8'h05);

        // Bypass at address 3
        @(negedge clock);
        waddr = 4'd3; raddr = 4'd3; data_in = 8'hA5; w_en = 1'b1;
        #1;
        expect_out("bypass_same_cycle", 8'hA5);
        @(posedge clock);
        #1;
        w_en = 1'b0; data_in = 8'h00;
        #1;
        expect_out("bypass_stored", 8'hA5);

        // Address isolation
        raddr = 4'd7;
        write_word(4'd2, 8'h11);
        write_word(4'd15, 8'h22);
        read_at("iso_addr2", 4'd2, 8'h11);
        read_at("iso_addr15", 4'd15, 8'h22);
        read_at("iso_addr7", 4'd7, 8'h00);

        // Concurrent write to 5 while reading 4
        write_word(4'd4, 8'h33);
        @(negedge clock);
        raddr = 4'd4; waddr = 4'd5; data_in = 8'h44; w_en = 1'b1;
        #1;
        expect_out("concurrent_before_edge", 8'h33);
        @(posedge clock);
        #1;
        expect_out("concurrent_after_edge", 8'h33);
        w_en = 1'b0;
        read_at("concurrent_addr5", 4'd5, 8'h44);

        // Back-to-back writes to one address on consecutive edges
        @(negedge clock);
        waddr = 4'd9; data_in = 8'h01; w_en = 1'b1; raddr = 4'd0;
        @(negedge clock);
        data_in = 8'h02;
        @(posedge clock);
        #1;
        w_en = 1'b0;
        read_at("back_to_back", 4'd9, 8'h02);

        // Fill everything, then asynchronous reset pulse between edges
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = {i[3:0], 4'hA};
            write_word(i[3:0], d);
        end
        read_at("fill_addr12", 4'd12, 8'hCA);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset_immediate", 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_at($sformatf("cleared_addr%0d", i), i[3:0], 8'h00);
        end

        // Write held across an edge during reset is discarded
        @(negedge clock);
        reset = 1'b1; w_en = 1'b1; waddr = 4'd6; raddr = 4'd6; data_in = 8'hFF;
        #1;
        expect_out("reset_bypass_suppressed", 8'h00);
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0; w_en = 1'b0;
        #1;
        expect_out("write_during_reset", 8'h00);

        // Write at the first edge after reset release commits
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; w_en = 1'b1; waddr = 4'd8; data_in = 8'h5A; raddr = 4'd6;
        @(posedge clock);
        #1;
        w_en = 1'b0;
        read_at("write_at_release_edge", 4'd8, 8'h5A);

        // Reset mid-cycle with a pending write clears and discards it
        write_word(4'd10, 8'h66);
        read_at("pre_midreset_addr10", 4'd10, 8'h66);
        @(negedge clock);
        w_en = 1'b1; waddr = 4'd10; data_in = 8'h77;
        #1;
        reset = 1'b1;
        #1;
        reset = 1'b0; w_en = 1'b0;
        read_at("midreset_addr10", 4'd10, 8'h00);
        read_at("midreset_addr8", 4'd8, 8'h00);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            #1;
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the number of storage entries.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the data word width in bits.
REQ-003 The block SHALL have port clock, input, 1 bit; it is the single clock, and all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; it is asynchronous and active-high.
REQ-005 The block SHALL have port waddr, input, $clog2(WIDTH) bits (4 at default); it is the write address.
REQ-006 The block SHALL have port raddr, input, $clog2(WIDTH) bits (4 at default); it is the read address.
REQ-007 The block SHALL have port w_en, input, 1 bit; it is the write enable and is active-high.
REQ-008 The block SHALL have port data_in, input, DEPTH bits; it is the write data.
REQ-009 The block SHALL have port data_out, output, DEPTH bits; it is the read data.

Function
REQ-010 Storage SHALL be WIDTH entries of DEPTH bits each, indexed 0..WIDTH-1.
REQ-011 Write behaviour SHALL be as follows.
- Occurs on a rising clock edge when w_en=1 and reset=0.
- mem[waddr] <= data_in.
- No other entry changes.
REQ-012 When w_en=0 at a rising edge, no entry SHALL change.
REQ-013 Read SHALL be combinational with zero-cycle latency: data_out = mem[raddr] whenever it is not bypassed or in reset.
REQ-014 Write-first bypass SHALL apply: when w_en=1, waddr==raddr and reset=0, data_out SHALL equal data_in combinationally, in the same cycle, before the edge commits.
REQ-015 A simultaneous read and write to different addresses SHALL return the stored value at raddr, unaffected by the write.
REQ-016 Out-of-range addresses (only possible when WIDTH is not a power of two) SHALL behave as follows.
- A write to an address >= WIDTH is ignored.
- A read from an address >= WIDTH returns 0.
- Bypass does not apply to such addresses.
REQ-017 Back-to-back writes to the same address on consecutive edges SHALL leave the last written value.
REQ-018 data_out SHALL never be X once reset has been asserted at least once.

Reset
REQ-019 Reset assertion SHALL asynchronously clear all WIDTH entries to 0 without waiting for a clock edge.
REQ-020 While reset=1, data_out SHALL be 0, with bypass suppressed, and all writes SHALL be ignored regardless of w_en.
REQ-021 Reset deassertion SHALL take effect for the first rising edge at which reset is sampled low, and a write presented at that edge SHALL commit.
REQ-022 Reset asserted mid-operation, including during a cycle with w_en=1, SHALL discard the pending write and clear the memory.

Verification
REQ-023 Write then read: reset, then waddr=0, data_in=5, w_en=1, raddr=0 for one edge, then w_en=0 -> data_out=5.
REQ-024 Bypass: w_en=1, waddr=raddr=3, data_in=8'hA5 before the edge -> data_out=8'hA5 immediately; after the edge with w_en=0, data_out=8'hA5 from storage.
REQ-025 Address isolation: write 8'h11 to address 2 and 8'h22 to address 15 -> reading address 2 gives 8'h11, address 15 gives 8'h22, and address 7 gives 0.
REQ-026 Concurrent different addresses: with mem[4]=8'h33, write 8'h44 to address 5 while raddr=4 -> data_out=8'h33 throughout.
REQ-027 Async reset: fill addresses 0..15 with nonzero data, then pulse reset between clock edges -> data_out=0 at once, and every address reads 0 afterwards.
REQ-028 Write during reset: hold reset=1 with w_en=1, waddr=6, data_in=8'hFF across an edge, then release reset -> address 6 reads 0.
